// File: rtl/sram_32x128_1rw_leak_if.sv
// Purpose : Bus bundle for the single-port 32x128 SRAM with leak monitor.
//           Carries the active-low chip select / write enable, address,
//           write data, registered read data and the leak observation word.
// Modports: master - drives csb0/web0/addr0/din0, observes dout0/trojan_out
//           slave  - the memory side of the same signals
interface sram_32x128_1rw_leak_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 7
);
    logic                  csb0;
    logic                  web0;
    logic [ADDR_WIDTH-1:0] addr0;
    logic [DATA_WIDTH-1:0] din0;
    logic [DATA_WIDTH-1:0] dout0;
    logic [DATA_WIDTH-1:0] trojan_out;

    modport master (
        output csb0,
        output web0,
        output addr0,
        output din0,
        input  dout0,
        input  trojan_out
    );

    modport slave (
        input  csb0,
        input  web0,
        input  addr0,
        input  din0,
        output dout0,
        output trojan_out
    );
endinterface

// File: rtl/sram_32x128_1rw_leak.sv
// Purpose : Single-port 32-bit x 128-word synchronous SRAM model with one
//           shared read/write port and active-low controls. A hidden monitor
//           counts consecutive writes of TRIG_DATA to TRIG_ADDR; after
//           TRIG_COUNT of them it arms a sticky leak that continuously
//           exposes the word at TRIG_ADDR on trojan_out.
// Ports   : clk0 - clock, all state on rising edge
//           rst0 - asynchronous active-high reset (memory array not cleared)
//           bus  - slave side of sram_32x128_1rw_leak_if:
//                  csb0 (chip select, low active), web0 (write enable, low
//                  active), addr0, din0, dout0 (registered read data),
//                  trojan_out (leaked word, 0 until armed)
module sram_32x128_1rw_leak #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 7,
    parameter int                    RAM_DEPTH  = 1 << ADDR_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] TRIG_ADDR  = 7'd1,
    parameter logic [DATA_WIDTH-1:0] TRIG_DATA  = 32'hDEADBEEF,
    parameter int                    TRIG_COUNT = 3
) (
    input  logic                  clk0,
    input  logic                  rst0,
    sram_32x128_1rw_leak_if.slave bus
);

    // Saturation value of the 2-bit match counter.
    localparam logic [1:0] TRIG_COUNT_C = 2'(TRIG_COUNT);

    logic [DATA_WIDTH-1:0] mem_r [RAM_DEPTH];

    logic [1:0]            count_r;
    logic [1:0]            count_next_s;
    logic                  armed_r;
    logic                  armed_next_s;
    logic [DATA_WIDTH-1:0] dout_r;
    logic [DATA_WIDTH-1:0] dout_next_s;
    logic [DATA_WIDTH-1:0] trojan_r;
    logic [DATA_WIDTH-1:0] trojan_next_s;

    logic                  wr_s;
    logic                  rd_s;
    logic                  wr_trig_addr_s;
    logic                  trig_hit_s;

    assign wr_s           = (bus.csb0 == 1'b0) && (bus.web0 == 1'b0);
    assign rd_s           = (bus.csb0 == 1'b0) && (bus.web0 == 1'b1);
    assign wr_trig_addr_s = wr_s && (bus.addr0 == TRIG_ADDR);
    assign trig_hit_s     = wr_trig_addr_s && (bus.din0 == TRIG_DATA);

    // Storage array: no reset so contents survive rst0; writes blocked during reset.
    always_ff @(posedge clk0) begin
        if (wr_s && !rst0) begin
            mem_r[bus.addr0] <= bus.din0;
        end
    end

    // Next-state logic for read data, match counter, arm flag and leak word.
    always_comb begin
        count_next_s  = count_r;
        armed_next_s  = armed_r;
        dout_next_s   = dout_r;
        trojan_next_s = trojan_r;

        if (rd_s) begin
            dout_next_s = mem_r[bus.addr0];
        end else begin
            dout_next_s = dout_r;
        end

        // Only write cycles move the counter; reads and idle cycles keep it.
        if (wr_s) begin
            if (trig_hit_s) begin
                if (count_r != TRIG_COUNT_C) begin
                    count_next_s = count_r + 2'd1;
                end else begin
                    count_next_s = count_r;
                end
            end else begin
                count_next_s = 2'd0;
            end
        end else begin
            count_next_s = count_r;
        end

        if (count_next_s == TRIG_COUNT_C) begin
            armed_next_s = 1'b1;
        end else begin
            armed_next_s = armed_r;
        end

        // Write-through so trojan_out shows the new word on the arming edge itself.
        if (armed_next_s) begin
            if (wr_trig_addr_s) begin
                trojan_next_s = bus.din0;
            end else begin
                trojan_next_s = mem_r[TRIG_ADDR];
            end
        end else begin
            trojan_next_s = trojan_r;
        end
    end

    // Control and output registers, cleared asynchronously by rst0.
    always_ff @(posedge clk0 or posedge rst0) begin
        if (rst0) begin
            count_r  <= 2'd0;
            armed_r  <= 1'b0;
            dout_r   <= {DATA_WIDTH{1'b0}};
            trojan_r <= {DATA_WIDTH{1'b0}};
        end else begin
            count_r  <= count_next_s;
            armed_r  <= armed_next_s;
            dout_r   <= dout_next_s;
            trojan_r <= trojan_next_s;
        end
    end

    assign bus.dout0      = dout_r;
    assign bus.trojan_out = trojan_r;

endmodule

// File: tb/tb_sram_32x128_1rw_leak.sv
module tb_sram_32x128_1rw_leak;

    localparam logic [31:0] MAGIC = 32'hDEADBEEF;

    logic clk0;
    logic rst0;

    sram_32x128_1rw_leak_if bus ();

    sram_32x128_1rw_leak dut (
        .clk0 (clk0),
        .rst0 (rst0),
        .bus  (bus)
    );

    initial clk0 = 1'b0;
    always #5 clk0 = ~clk0;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model: word array, written flags, match count and arm flag.
    logic [31:0] m_mem [128];
    bit          m_valid [128];
    int          m_cnt;
    bit          m_armed;
    logic [31:0] m_dout;
    bit          m_dout_known;

    typedef struct {
        logic        csb;
        logic        web;
        logic [6:0]  addr;
        logic [31:0] din;
        logic        chk_dout;
        logic [31:0] exp_dout;
        logic [31:0] exp_trojan;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void add(input logic c, input logic w, input logic [6:0] a,
                                input logic [31:0] d, input logic cd,
                                input logic [31:0] ed, input logic [31:0] et);
        vec_t v;
        v.csb = c; v.web = w; v.addr = a; v.din = d;
        v.chk_dout = cd; v.exp_dout = ed; v.exp_trojan = et;
        vecs.push_back(v);
    endfunction

    function automatic void model_reset();
        m_cnt = 0;
        m_armed = 1'b0;
        m_dout = 32'h0;
        m_dout_known = 1'b1;
    endfunction

    function automatic logic [31:0] model_trojan();
        return m_armed ? m_mem[1] : 32'h0;
    endfunction

    // Drive one operation across one rising edge; outputs sampled 1 time unit later.
    task automatic do_cycle(input logic c, input logic w, input logic [6:0] a, input logic [31:0] d);
        bus.csb0 = c; bus.web0 = w; bus.addr0 = a; bus.din0 = d;
        @(posedge clk0);
        #1;
        if (!c && !w) begin
            m_mem[a] = d;
            m_valid[a] = 1'b1;
            if (a == 7'd1 && d == MAGIC) m_cnt = (m_cnt < 3) ? m_cnt + 1 : 3;
            else m_cnt = 0;
            if (m_cnt == 3) m_armed = 1'b1;
        end else if (!c && w) begin
            m_dout_known = m_valid[a];
            m_dout = m_mem[a];
        end
    endtask

    initial begin
        for (int i = 0; i < 128; i++) m_valid[i] = 1'b0;
        model_reset();
        bus.csb0 = 1'b1; bus.web0 = 1'b1; bus.addr0 = 7'd0; bus.din0 = 32'h0;
        rst0 = 1'b1;
        #1;
        check("reset_dout", bus.dout0, 32'h0);
        check("reset_trojan", bus.trojan_out, 32'h0);
        @(posedge clk0); @(posedge clk0); #1;
        rst0 = 1'b0;

        // Basic write/read, broken sequence, deselected writes, arming, tracking.
        add(0, 0, 7'd10, 32'hFACECAFE, 1, 32'h0,        32'h0);
        add(0, 1, 7'd10, 32'h0,        1, 32'hFACECAFE, 32'h0);
        add(0, 0, 7'd1,  MAGIC,        1, 32'hFACECAFE, 32'h0);
        add(0, 0, 7'd1,  MAGIC,        1, 32'hFACECAFE, 32'h0);
        add(0, 0, 7'd2,  32'h0,        1, 32'hFACECAFE, 32'h0);
        add(0, 0, 7'd1,  MAGIC,        1, 32'hFACECAFE, 32'h0);
        add(0, 0, 7'd1,  32'h11111111, 1, 32'hFACECAFE, 32'h0);
        add(1, 0, 7'd1,  MAGIC,        1, 32'hFACECAFE, 32'h0);
        add(1, 0, 7'd1,  MAGIC,        1, 32'hFACECAFE, 32'h0);
        add(1, 0, 7'd1,  MAGIC,        1, 32'hFACECAFE, 32'h0);
        add(0, 1, 7'd1,  32'h0,        1, 32'h11111111, 32'h0);
        add(0, 0, 7'd1,  MAGIC,        0, 32'h0,        32'h0);
        add(0, 1, 7'd10, 32'h0,        1, 32'hFACECAFE, 32'h0);
        add(0, 0, 7'd1,  MAGIC,        0, 32'h0,        32'h0);
        add(0, 1, 7'd10, 32'h0,        1, 32'hFACECAFE, 32'h0);
        add(0, 0, 7'd1,  MAGIC,        1, 32'hFACECAFE, MAGIC);
        add(0, 1, 7'd1,  32'h0,        1, MAGIC,        MAGIC);
        add(0, 0, 7'd1,  32'h12345678, 1, MAGIC,        32'h12345678);
        add(0, 1, 7'd1,  32'h0,        1, 32'h12345678, 32'h12345678);
        add(1, 1, 7'd1,  32'h0,        1, 32'h12345678, 32'h12345678);
        add(0, 0, 7'd5,  32'hA5A5A5A5, 1, 32'h12345678, 32'h12345678);
        add(0, 0, 7'd127,32'h7F7F7F7F, 1, 32'h12345678, 32'h12345678);
        add(0, 1, 7'd127,32'h0,        1, 32'h7F7F7F7F, 32'h12345678);

        for (int i = 0; i < vecs.size(); i++) begin
            do_cycle(vecs[i].csb, vecs[i].web, vecs[i].addr, vecs[i].din);
            if (vecs[i].chk_dout) check($sformatf("vec%0d_dout", i), bus.dout0, vecs[i].exp_dout);
            check($sformatf("vec%0d_trojan", i), bus.trojan_out, vecs[i].exp_trojan);
        end

        // Asynchronous reset mid-cycle while armed: outputs clear before any edge.
        #2;
        rst0 = 1'b1;
        #1;
        check("midrst_dout", bus.dout0, 32'h0);
        check("midrst_trojan", bus.trojan_out, 32'h0);
        @(posedge clk0); #1;
        rst0 = 1'b0;
        model_reset();
        do_cycle(0, 1, 7'd10, 32'h0);
        check("after_rst_mem", bus.dout0, 32'hFACECAFE);
        check("after_rst_trojan", bus.trojan_out, 32'h0);
        do_cycle(0, 0, 7'd1, MAGIC);
        check("after_rst_disarmed", bus.trojan_out, 32'h0);

        // Four matching writes: arm on the third, count saturates on the fourth.
        do_cycle(0, 0, 7'd1, MAGIC);
        check("sat_2nd", bus.trojan_out, 32'h0);
        do_cycle(0, 0, 7'd1, MAGIC);
        check("sat_3rd", bus.trojan_out, MAGIC);
        do_cycle(0, 0, 7'd1, MAGIC);
        check("sat_4th", bus.trojan_out, MAGIC);

        // Randomized operations against the reference model, with occasional resets.
        for (int n = 0; n < 400; n++) begin
            logic       c, w;
            logic [6:0] a;
            logic [31:0] d;
            int sel;
            if ($urandom_range(0, 99) == 0) begin
                rst0 = 1'b1;
                @(posedge clk0); #1;
                rst0 = 1'b0;
                model_reset();
            end
            c = ($urandom_range(0, 5) == 0);
            w = $urandom_range(0, 1);
            sel = $urandom_range(0, 3);
            a = (sel == 0) ? 7'd1 : (sel == 1) ? 7'd10 : 7'($urandom_range(0, 127));
            d = ($urandom_range(0, 1) == 1) ? MAGIC : $urandom;
            if (a == 7'd1 && $urandom_range(0, 3) != 0) d = MAGIC;
            do_cycle(c, w, a, d);
            if (m_dout_known) check($sformatf("rnd%0d_dout", n), bus.dout0, m_dout);
            check($sformatf("rnd%0d_trojan", n), bus.trojan_out, model_trojan());
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
